// File: rtl/uart_tx_periph.sv
// uart_tx_periph: bus-mapped 8N1 UART transmitter with TX FIFO, baud divider and drain interrupt (ports: clk, reset, CS_N/RD_N/WR_N, Addr, DataIn, DataOut, Intr, TXD)
module uart_tx_periph #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr,
  output logic        TXD
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] fcnt_q, fcnt_d;
  logic [15:0] baud_q, baud_d, div_q, div_d, tmr_q, tmr_d;
  logic [1:0] ctrl_q, ctrl_d, state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic ovf_q, ovf_d, txd_q, txd_d, intr_q, intr_d;
  logic hit, wr_en, push, pop, empty, full, busy, tick, unused_ok;
  logic [31:0] status;
  assign hit = ~CS_N && Addr[11:4] == 8'h0 && Addr[1:0] == 2'b00;
  assign wr_en = hit & ~WR_N;
  assign empty = fcnt_q == '0;
  assign full = fcnt_q == (AW+1)'(FIFO_DEPTH);
  assign busy = state_q != IDLE;
  assign tick = tmr_q == div_q;
  // a frame can start from IDLE or directly from the last STOP clock, giving back-to-back frames
  assign pop = ctrl_q[0] & ~empty & (state_q == IDLE | (state_q == STOP & tick));
  // a push to a full FIFO still fits when the same edge pops
  assign push = wr_en & Addr[3:2] == 2'd0 & (~full | pop);
  assign status = {19'b0, 5'(fcnt_q), 4'b0, ovf_q, empty, full, busy};
  assign DataOut = (hit & ~RD_N) ? (Addr[3:2] == 2'd1 ? status :
                                    Addr[3:2] == 2'd2 ? {16'b0, baud_q} :
                                    Addr[3:2] == 2'd3 ? {30'b0, ctrl_q} : 32'b0) : 32'b0;
  assign Intr = intr_q;
  assign TXD = txd_q;
  assign unused_ok = ^DataIn[31:16];
  always_comb begin
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    fcnt_d = fcnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ovf_d = (wr_en && Addr[3:2] == 2'd1 && DataIn[3]) ? 1'b0 :
            (wr_en && Addr[3:2] == 2'd0 && full && !pop) ? 1'b1 : ovf_q;
    baud_d = (wr_en && Addr[3:2] == 2'd2) ? DataIn[15:0] : baud_q;
    ctrl_d = (wr_en && Addr[3:2] == 2'd3) ? DataIn[1:0] : ctrl_q;
    intr_d = ctrl_q[1] & empty & ~busy;
    tmr_d = (state_q == IDLE || tick) ? 16'd0 : tmr_q + 16'd1;
    state_d = state_q;
    div_d = div_q;
    idx_d = idx_q;
    sh_d = sh_q;
    txd_d = txd_q;
    case (state_q)
      START: if (tick) begin
        state_d = DATA;
        txd_d = sh_q[0];
        idx_d = 3'd0;
      end
      DATA: if (tick) begin
        sh_d = sh_q >> 1;
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
        txd_d = idx_q == 3'd7 ? 1'b1 : sh_q[1];
      end
      STOP: if (tick) begin
        state_d = IDLE;
        txd_d = 1'b1;
      end
      default: ;
    endcase
    // divider is latched per frame so BAUDDIV writes only affect later frames
    if (pop) begin
      state_d = START;
      txd_d = 1'b0;
      div_d = baud_q;
      sh_d = mem_q[rp_q];
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= DataIn[7:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      fcnt_q <= '0;
      ovf_q <= 1'b0;
      baud_q <= 16'(DEFAULT_DIV);
      ctrl_q <= 2'b01;
      intr_q <= 1'b0;
      tmr_q <= 16'd0;
      state_q <= IDLE;
      div_q <= 16'd0;
      idx_q <= 3'd0;
      sh_q <= 8'd0;
      txd_q <= 1'b1;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      fcnt_q <= fcnt_d;
      ovf_q <= ovf_d;
      baud_q <= baud_d;
      ctrl_q <= ctrl_d;
      intr_q <= intr_d;
      tmr_q <= tmr_d;
      state_q <= state_d;
      div_q <= div_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      txd_q <= txd_d;
    end
  end
endmodule
